// File: rtl/matrix_stream_transposer.sv
// matrix_stream_transposer: buffers a vecSize x vecSize byte matrix row-wise, emits it column-wise; MATRIX_STREAM_BYPASS_EN adds a per-matrix row bypass
module matrix_stream_transposer #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [regSize-1:0] in_data,
`ifdef MATRIX_STREAM_BYPASS_EN
  input  logic               bypass,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [regSize-1:0] out_data,
  output logic               out_last,
  output logic               busy
);
  localparam int IW = vecSize > 1 ? $clog2(vecSize) : 1;
  localparam logic [IW-1:0] LAST = IW'(vecSize - 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [regSize-1:0] mem [vecSize];
  logic [regSize-1:0] col, drain_word;
  logic in_fire, out_fire, at_last;
  if (regSize != 8 * vecSize) begin : g_chk
    $error("regSize must equal 8*vecSize");
  end
  assign in_ready  = state == FILL;
  assign out_valid = state == DRAIN;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign at_last   = idx == LAST;
  assign out_last  = out_valid & at_last;
  assign busy      = (state == DRAIN) | (idx != '0);
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (clr) begin
      state_nx = FILL;
      idx_nx   = '0;
    end else if (in_fire | out_fire) begin
      idx_nx   = at_last ? '0 : idx + 1'b1;
      state_nx = at_last ? (in_fire ? DRAIN : FILL) : state;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < vecSize; i++) mem[i] <= '0;
    end else if (in_fire & ~clr) begin
      mem[idx] <= in_data;
    end
  end
  always_comb begin
    col = '0;
    for (int i = 0; i < vecSize; i++)
      for (int j = 0; j < vecSize; j++)
        if (idx == IW'(j)) col[regSize-1-8*i -: 8] = mem[i][regSize-1-8*j -: 8];
  end
`ifdef MATRIX_STREAM_BYPASS_EN
  logic byp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byp_q <= 1'b0;
    else if (in_fire & ~clr & (idx == '0)) byp_q <= bypass;
  end
  assign drain_word = byp_q ? mem[idx] : col;
`else
  assign drain_word = col;
`endif
  assign out_data = out_valid ? drain_word : '0;
endmodule

// File: tb/tb_matrix_stream_transposer.sv
// tb_matrix_stream_transposer: directed scenario tasks with hand-computed columns
module tb_matrix_stream_transposer;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 0, bypass = 0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  int vecs = 0, errs = 0;
  logic [31:0] ra [4] = '{32'h7b5b5465, 32'h73745665, 32'h63746f72, 32'h5d53475d};
  logic [31:0] ca [4] = '{32'h7b73635d, 32'h5b747453, 32'h54566f47, 32'h6565725d};
  logic [31:0] rb [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] cb [4] = '{32'h0004080c, 32'h0105090d, 32'h02060a0e, 32'h03070b0f};
  logic [6:0] pat = 7'b1001011;
  matrix_stream_transposer dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
`ifdef MATRIX_STREAM_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));
  always #5 clk = ~clk;
  task automatic fill(input int m, input logic byp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = m == 0 ? ra[i] : rb[i];
      bypass   = i == 0 ? byp : 1'b0;
    end
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    vecs++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset out_last got %b want 0", out_last); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy got %b want 0", busy); end
    vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL reset out_data got %h want 0", out_data); end
    rst_n = 1;
  endtask
  task automatic test_transpose;
    out_ready = 1;
    fill(0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic col%0d out_valid got %b want 1", j, out_valid); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL basic col%0d in_ready got %b want 0", j, in_ready); end
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL basic col%0d out_data got %h want %h", j, out_data, ca[j]); end
      vecs++; if (out_last !== (j == 3)) begin errs++; $display("FAIL basic col%0d out_last got %b want %b", j, out_last, j == 3); end
      @(negedge clk);
    end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic end out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic end in_ready got %b want 1", in_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic end busy got %b want 0", busy); end
  endtask
  task automatic test_backpressure;
    int j = 0;
    out_ready = 0;
    fill(0, 1'b0);
    for (int p = 0; p < 7; p++) begin
      out_ready = pat[6-p];
      in_valid  = p < 6;
      in_data   = 32'hdeadbeef;
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp step%0d out_valid got %b want 1", p, out_valid); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp step%0d in_ready got %b want 0", p, in_ready); end
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL bp step%0d out_data got %h want %h", p, out_data, ca[j]); end
      vecs++; if (out_last !== (j == 3)) begin errs++; $display("FAIL bp step%0d out_last got %b want %b", p, out_last, j == 3); end
      @(negedge clk);
      if (pat[6-p]) j++;
    end
    in_valid = 0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp end out_valid got %b want 0", out_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bp end busy got %b want 0", busy); end
  endtask
  task automatic test_back_to_back;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = ra[i];
    end
    @(negedge clk);
    in_data = rb[0];
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL b2b A col%0d out_data got %h want %h", j, out_data, ca[j]); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b A col%0d in_ready got %b want 0", j, in_ready); end
      @(negedge clk);
    end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b B row0 in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_data = rb[i];
      @(negedge clk);
    end
    in_valid = 0;
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== cb[j]) begin errs++; $display("FAIL b2b B col%0d out_data got %h want %h", j, out_data, cb[j]); end
      vecs++; if (out_last !== (j == 3)) begin errs++; $display("FAIL b2b B col%0d out_last got %b want %b", j, out_last, j == 3); end
      @(negedge clk);
    end
  endtask
  task automatic test_abort;
    out_ready = 1;
    @(negedge clk);
    in_valid = 1;
    in_data  = rb[0];
    @(negedge clk);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL abort busy after row0 got %b want 1", busy); end
    in_data = rb[1];
    @(negedge clk);
    clr = 1;
    in_data = rb[2];
    @(negedge clk);
    clr = 0;
    in_valid = 0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL abort busy after clr got %b want 0", busy); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL abort in_ready after clr got %b want 1", in_ready); end
    fill(0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL abort col%0d out_data got %h want %h", j, out_data, ca[j]); end
      @(negedge clk);
    end
  endtask
  task automatic test_async_reset;
    out_ready = 1;
    fill(1, 1'b0);
    vecs++; if (out_data !== cb[0]) begin errs++; $display("FAIL arst col0 out_data got %h want %h", out_data, cb[0]); end
    @(negedge clk);
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL arst out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL arst in_ready got %b want 1", in_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL arst busy got %b want 0", busy); end
    vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL arst out_data got %h want 0", out_data); end
    #1 rst_n = 1;
    out_ready = 1;
    fill(0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL arst after col%0d out_data got %h want %h", j, out_data, ca[j]); end
      @(negedge clk);
    end
  endtask
`ifdef MATRIX_STREAM_BYPASS_EN
  task automatic test_bypass;
    out_ready = 1;
    fill(0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== ra[j]) begin errs++; $display("FAIL bypass row%0d out_data got %h want %h", j, out_data, ra[j]); end
      vecs++; if (out_last !== (j == 3)) begin errs++; $display("FAIL bypass row%0d out_last got %b want %b", j, out_last, j == 3); end
      @(negedge clk);
    end
    fill(0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      vecs++; if (out_data !== ca[j]) begin errs++; $display("FAIL bypass off col%0d out_data got %h want %h", j, out_data, ca[j]); end
      @(negedge clk);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_transpose;
    test_backpressure;
    test_back_to_back;
    test_abort;
    test_async_reset;
`ifdef MATRIX_STREAM_BYPASS_EN
    test_bypass;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
